keycode_fifo: RTL and testbench

Parametrised successor to the keyboard character buffer. Consumes raw PS/2 set-2 scan codes and tracks make/break/extended prefixes, shift and caps-lock state. Translates key presses to ASCII and queues them in a configurable-depth FIFO with full, count and overflow reporting. Sits between the PS/2 receiver and the display/UART consumer.

---
 rtl/keycode_fifo.sv | 154 +++++++++++++++
 tb/tb_keycode_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_fifo.sv
// PS/2 set-2 scan-code decoder feeding an ASCII character FIFO.
// Tracks make/break/extended prefixes plus shift and caps-lock state.
module keycode_fifo #(
  parameter int         ADDR_W       = 8,
  parameter logic [7:0] BREAK_CODE   = 8'hF0,
  parameter logic [7:0] EXT_CODE     = 8'hE0,
  parameter bit         DROP_UNKNOWN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        code_in,
  input  logic              code_valid,
  input  logic              read,
  output logic [7:0]        char_out,
  output logic              char_valid,
  output logic              read_ready,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              shift_state,
  output logic              caps_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {NORM, BREAK, EXT, EXT_BREAK} state_t;

  state_t            state, state_nxt;
  logic              lshift, rshift, caps;
  logic              lshift_nxt, rshift_nxt, caps_nxt;
  logic              push_req;
  logic [8:0]        xlate_res;
  logic [7:0]        push_char_p0;
  logic              push, pop, drop;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]        mem [DEPTH];

  // Returns {known, ascii}; letters use a 0..25 index so case is a single add.
  function automatic logic [8:0] xlate(input logic [7:0] code, input logic upper);
    logic [4:0] idx;
    logic       is_letter;
    logic [8:0] res;
    idx       = 5'd0;
    is_letter = 1'b1;
    res       = 9'h000;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
      8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
      8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
      8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
      8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
      8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
      8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
    if (is_letter) begin
      res = {1'b1, (upper ? 8'h41 : 8'h61) + {3'b000, idx}};
    end else begin
      case (code)
        8'h45: res = 9'h130;  8'h16: res = 9'h131;  8'h1E: res = 9'h132;
        8'h26: res = 9'h133;  8'h25: res = 9'h134;  8'h2E: res = 9'h135;
        8'h36: res = 9'h136;  8'h3D: res = 9'h137;  8'h3E: res = 9'h138;
        8'h46: res = 9'h139;
        8'h29: res = 9'h120;  8'h5A: res = 9'h10D;  8'h66: res = 9'h108;
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

  assign shift_state  = lshift | rshift;
  assign caps_state   = caps;
  assign xlate_res    = xlate(code_in, shift_state ^ caps);
  assign push_char_p0 = xlate_res[8] ? xlate_res[7:0] : 8'h00;

  always_comb begin
    state_nxt  = state;
    lshift_nxt = lshift;
    rshift_nxt = rshift;
    caps_nxt   = caps;
    push_req   = 1'b0;
    if (code_valid) begin
      case (state)
        NORM: begin
          if (code_in == BREAK_CODE)    state_nxt  = BREAK;
          else if (code_in == EXT_CODE) state_nxt  = EXT;
          else if (code_in == 8'h12)    lshift_nxt = 1'b1;
          else if (code_in == 8'h59)    rshift_nxt = 1'b1;
          else if (code_in == 8'h58)    caps_nxt   = ~caps;
          else                          push_req   = xlate_res[8] | ~DROP_UNKNOWN;
        end
        BREAK: begin
          state_nxt = NORM;
          if (code_in == 8'h12) lshift_nxt = 1'b0;
          if (code_in == 8'h59) rshift_nxt = 1'b0;
        end
        EXT:       state_nxt = (code_in == BREAK_CODE) ? EXT_BREAK : NORM;
        default:   state_nxt = NORM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= NORM;
      lshift <= 1'b0;
      rshift <= 1'b0;
      caps   <= 1'b0;
    end else begin
      state  <= state_nxt;
      lshift <= lshift_nxt;
      rshift <= rshift_nxt;
      caps   <= caps_nxt;
    end
  end

  // FIFO stage: a same-cycle pop frees the slot for a push into a full buffer.
  assign read_ready = |count;
  assign full       = count[ADDR_W];
  assign pop        = read & read_ready;
  assign push       = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_char_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      char_valid <= pop;
      if (pop)  char_out <= mem[rd_ptr];
      if (push) wr_ptr   <= wr_ptr + 1'b1;
      if (pop)  rd_ptr   <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keycode_fifo.sv
// Scoreboard bench for keycode_fifo: a 4-deep, keep-unknown instance carries
// most traffic; an 8-deep, drop-unknown instance covers the discard path.
module tb_keycode_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_in;
  logic       code_valid, read, clr_overflow;
  logic [7:0] char_out;
  logic       char_valid, read_ready, full, overflow, shift_state, caps_state;
  logic [2:0] count;

  logic [7:0] code_b;
  logic       valid_b, read_b, clr_b;
  logic [7:0] char_out_b;
  logic       char_valid_b, read_ready_b, full_b, overflow_b, shift_b, caps_b;
  logic [3:0] count_b;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic       ovf_m = 1'b0;

  always #5 clk = ~clk;

  keycode_fifo #(.ADDR_W(2), .DROP_UNKNOWN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .read(read), .char_out(char_out), .char_valid(char_valid),
    .read_ready(read_ready), .full(full), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow), .shift_state(shift_state), .caps_state(caps_state)
  );

  keycode_fifo #(.ADDR_W(3), .DROP_UNKNOWN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .code_in(code_b), .code_valid(valid_b),
    .read(read_b), .char_out(char_out_b), .char_valid(char_valid_b),
    .read_ready(read_ready_b), .full(full_b), .count(count_b), .overflow(overflow_b),
    .clr_overflow(clr_b), .shift_state(shift_b), .caps_state(caps_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One code byte; q says whether it should be queued and ch the character.
  task automatic send(input logic [7:0] c, input bit q, input logic [7:0] ch);
    @(negedge clk);
    code_in    = c;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    if (q) begin
      if (sb.size() < 4) sb.push_back(ch);
      else ovf_m = 1'b1;
    end
    chk("count_after_send", count, sb.size());
  endtask

  task automatic rd();
    bit         had;
    logic [7:0] e;
    had = (sb.size() != 0);
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk("char_valid", char_valid, had);
    if (had) begin
      e = sb.pop_front();
      chk("char_out", char_out, e);
    end
    chk("count_after_read", count, sb.size());
    chk("read_ready", read_ready, sb.size() != 0);
  endtask

  task automatic push_pop(input logic [7:0] c, input logic [7:0] ch);
    bit         had;
    logic [7:0] e;
    had = (sb.size() != 0);
    @(negedge clk);
    code_in    = c;
    code_valid = 1'b1;
    read       = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    read       = 1'b0;
    chk("pp_char_valid", char_valid, had);
    if (had) begin
      e = sb.pop_front();
      chk("pp_char_out", char_out, e);
    end
    sb.push_back(ch);
    chk("pp_count", count, sb.size());
  endtask

  task automatic drain();
    while (sb.size() != 0) rd();
  endtask

  initial begin
    rst = 1'b0; code_in = 8'h1C; code_valid = 1'b1; read = 1'b0; clr_overflow = 1'b0;
    code_b = 8'h00; valid_b = 1'b0; read_b = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_char_out", char_out, 8'h00);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_read_ready", read_ready, 0);
    chk("rst_full", full, 0);
    chk("rst_shift", shift_state, 0);
    chk("rst_caps", caps_state, 0);
    code_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_count", count, 0);

    // Basic make and pop
    send(8'h1C, 1, 8'h61);
    chk("ready_after_push", read_ready, 1);
    rd();
    @(negedge clk);
    chk("char_valid_one_cycle", char_valid, 0);

    // Shift press/release around letters
    send(8'h12, 0, 8'h00);
    chk("shift_held", shift_state, 1);
    send(8'h1C, 1, 8'h41);
    send(8'hF0, 0, 8'h00);
    send(8'h1C, 0, 8'h00);
    chk("shift_still_held", shift_state, 1);
    send(8'hF0, 0, 8'h00);
    send(8'h12, 0, 8'h00);
    chk("shift_released", shift_state, 0);
    send(8'h1C, 1, 8'h61);
    drain();

    // Caps XOR shift, right shift too
    send(8'h58, 0, 8'h00);
    chk("caps_on", caps_state, 1);
    send(8'h1C, 1, 8'h41);
    send(8'h59, 0, 8'h00);
    send(8'h1C, 1, 8'h61);
    send(8'hF0, 0, 8'h00);
    send(8'h59, 0, 8'h00);
    chk("rshift_released", shift_state, 0);
    send(8'h58, 0, 8'h00);
    chk("caps_off", caps_state, 0);
    drain();

    // Extended sequences queue nothing and return to NORM
    send(8'hE0, 0, 8'h00);
    send(8'hF0, 0, 8'h00);
    send(8'h1C, 0, 8'h00);
    send(8'hE0, 0, 8'h00);
    send(8'h75, 0, 8'h00);
    send(8'h1C, 1, 8'h61);
    drain();

    // Digits ignore shift; space, enter, backspace fill the FIFO
    send(8'h12, 0, 8'h00);
    send(8'h16, 1, 8'h31);
    send(8'hF0, 0, 8'h00);
    send(8'h12, 0, 8'h00);
    send(8'h29, 1, 8'h20);
    send(8'h5A, 1, 8'h0D);
    send(8'h66, 1, 8'h08);
    chk("full_at_4", full, 1);
    drain();
    chk("empty_not_full", full, 0);

    // Overflow
    for (int i = 0; i < 5; i++) send(8'h16, 1, 8'h31);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, ovf_m);
    @(negedge clk);
    code_in = 8'h16; code_valid = 1'b1; clr_overflow = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; clr_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    chk("ovf_count_held", count, 4);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    ovf_m = 1'b0;
    chk("ovf_cleared", overflow, ovf_m);

    // Push+pop while full, across pointer wrap
    push_pop(8'h1E, 8'h32);
    push_pop(8'h26, 8'h33);
    push_pop(8'h25, 8'h34);
    chk("pp_no_overflow", overflow, 0);
    chk("pp_full", full, 1);
    drain();
    push_pop(8'h1C, 8'h61);
    rd();
    rd();

    // Unknown make kept as 00 in this instance
    send(8'h05, 1, 8'h00);
    rd();

    // Reset mid-sequence
    send(8'h12, 0, 8'h00);
    send(8'hF0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_shift", shift_state, 0);
    chk("mid_rst_count", count, 0);
    send(8'h1C, 1, 8'h61);
    rd();

    // Drop-unknown instance
    @(negedge clk);
    code_b = 8'h05; valid_b = 1'b1;
    @(negedge clk);
    code_b = 8'h1C;
    @(negedge clk);
    valid_b = 1'b0;
    chk("b_count", count_b, 1);
    read_b = 1'b1;
    @(negedge clk);
    read_b = 1'b0;
    chk("b_char_valid", char_valid_b, 1);
    chk("b_char_out", char_out_b, 8'h61);
    chk("b_empty", read_ready_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
